axi4_burst_writer: RTL
======================

Name: axi4_burst_writer

Overview:
- AXI4 full-protocol write initiator that drives the 128-bit / 6-bit-address AXI4 slave ports of the RFSoC main block (DAC controller register and waveform slaves).
- Accepts write commands (address, burst length, ID) and a stream of 128-bit data beats, issues INCR bursts, and collects the B response.
- Used in simulation benches and by an on-chip sequencer in place of the PS master.

Parameters:
- ADDR_W, 6, AXI address width.
- DATA_W, 128, AXI data width; WSTRB width is DATA_W/8.
- ID_W, 16, AXI ID width; also the width of awuser.
- FIFO_DEPTH, 16, internal write-data FIFO depth; power of 2, at least 2.

Ports:
- m_axi_aclk  in  1  clock.
- m_axi_aresetn  in  1  synchronous active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when valid and ready are both high.
- cmd_addr  in  ADDR_W  burst start byte address.
- cmd_len  in  8  beats minus 1 (AXI awlen encoding).
- cmd_id  in  ID_W  transaction ID; also driven on awuser.
- din_valid  in  1  data beat valid.
- din_ready  out  1  high when the FIFO is not full.
- din_data  in  DATA_W  data beat.
- m_axi_awaddr/awburst/awid/awlen/awsize/awuser/awvalid  out  ADDR_W/2/ID_W/8/3/ID_W/1  AW channel.
- m_axi_awready  in  1.
- m_axi_wdata/wstrb/wlast/wvalid  out  DATA_W/DATA_W/8/1/1  W channel.
- m_axi_wready  in  1.
- m_axi_bid  in  ID_W.
- m_axi_bresp  in  2.
- m_axi_bvalid  in  1.
- m_axi_bready  out  1.
- done  out  1  one-cycle pulse when the B handshake completes.
- done_resp  out  2  bresp captured with done; held until the next done.
- id_err  out  1  sticky flag: bid did not match the issued awid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, applied synchronously while m_axi_aresetn=0:
  - Outputs cleared: all valids, bready, done, id_err, busy, done_resp=0.
  - FIFO flushed to empty.
  - State returns to IDLE.
  - Reset asserted mid-burst abandons the burst; no wlast or bready is generated afterwards.
- Constant fields: awburst=2'b01 (INCR); awsize=log2(DATA_W/8), which is 3'b100 at the default width; wstrb is all ones.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - cmd_ready=1.
  - On command handshake, register addr/len/id, load beat counter = cmd_len, go to ADDR.
  - The command address drives awaddr unchanged. Bits below awsize are passed through, not masked.
- ADDR:
  - awvalid=1, with fields stable until awready.
  - On awready: deassert awvalid next cycle, go to DATA.
- DATA:
  - wvalid = FIFO not empty; wdata = FIFO head, registered output, so zero bubble between beats.
  - Each wvalid&&wready pops the FIFO and decrements the beat counter.
  - wlast=1 exactly when counter==0.
  - The handshake with wlast moves the FSM to RESP.
  - A FIFO underrun inserts wvalid=0 cycles; protocol stays legal.
- RESP:
  - bready=1.
  - On bvalid: done=1 for one cycle; done_resp=bresp.
  - If bid != issued id, set id_err (sticky until reset).
  - Return to IDLE.
- Valid stability: once awvalid or wvalid is asserted, it stays high with stable payload until its ready (AXI rule).
- FIFO:
  - Push on din_valid&&din_ready; pop as above.
  - Simultaneous push and pop when full is allowed: din_ready reflects the pre-pop full state, so there is no push when full.
  - Pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1.
  - Data may be pushed in any state, including before its command.
- Latency:
  - Command handshake to awvalid: 1 cycle.
  - awready to first wvalid: 1 cycle when the FIFO is non-empty.
  - bvalid to done: 1 cycle.
- Only one outstanding transaction.
- cmd_len=0 gives a single beat with wlast on it.
- cmd_len=255 gives 256 beats; the counter must not wrap early.

Optional Feature:
- Macro: AXI4_BURST_WRITER_TIMEOUT_EN.
- When defined:
  - 16-bit watchdog counts cycles spent in RESP without bvalid.
  - At 65535 it forces done=1, done_resp=2'b10 (SLVERR), and a return to IDLE; bready deasserts.
  - The counter clears on entry to RESP.
- When not defined: RESP waits indefinitely; no counter logic is synthesized.

Test Plan:
- Single beat:
  - Stimulus: push 1 beat 128'hDEAD_BEEF, cmd addr=6'h10, len=0, id=16'h0005; slave always ready, bresp=0.
  - Required: awaddr=6'h10, awlen=0, awsize=3'b100, one W beat with wlast=1; done pulses with done_resp=0.
- Burst with backpressure:
  - Stimulus: 4-beat burst (len=3), data 1..4; wready toggles every other cycle.
  - Required: exactly 4 W handshakes in order 1,2,3,4; wlast only on beat 4; wdata held stable while wready=0.
- Error response and ID mismatch:
  - Stimulus: slave returns bresp=2'b10 and bid=16'h0006 for awid=16'h0005.
  - Required: done_resp=2'b10; id_err=1 and stays high through the next good transaction.
- FIFO full:
  - Stimulus: push 17 beats with no command.
  - Required: din_ready=0 after 16 beats.
  - Then issue len=15: all 16 beats drain in order and din_ready returns to 1.
- Reset mid-burst:
  - Stimulus: pull m_axi_aresetn low after beat 2 of an 8-beat burst.
  - Required: next cycle all valids=0, busy=0, FIFO empty; a fresh single-beat command then completes normally.
- Timeout (with AXI4_BURST_WRITER_TIMEOUT_EN):
  - Stimulus: slave never asserts bvalid.
  - Required: done pulses 65535 cycles after entering RESP, with done_resp=2'b10.

Source files
------------

// File: rtl/axi4_burst_writer.sv
// axi4_burst_writer
//   AXI4 write initiator for the RFSoC DAC controller register/waveform
//   slaves. Accepts one write command at a time (start address, awlen-coded
//   length, ID) plus a stream of data beats buffered in an internal FIFO.
//   It issues a single INCR burst and collects the B response.
//
// Ports
//   m_axi_aclk, m_axi_aresetn      clock, synchronous active-low reset
//   cmd_valid/ready/addr/len/id    write command (len = beats - 1)
//   din_valid/ready/data           data beat stream into the FIFO
//   m_axi_aw*, m_axi_w*, m_axi_b*  AXI4 write channels
//   done, done_resp                one-cycle completion pulse and its bresp
//   id_err                         sticky: bid differed from the issued awid
//   busy                           FSM is not idle
//
// Optional build macro
//   AXI4_BURST_WRITER_TIMEOUT_EN   adds a 16-bit RESP watchdog that
//                                  completes the transaction with SLVERR
//                                  when bvalid never arrives.
//
// state | meaning
// IDLE  | ready for a command
// ADDR  | awvalid high, waiting for awready
// DATA  | streaming FIFO beats on W until the wlast handshake
// RESP  | bready high, waiting for bvalid

module axi4_burst_writer #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 128,
  parameter int ID_W       = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                m_axi_aclk,
  input  logic                m_axi_aresetn,

  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [7:0]          cmd_len,
  input  logic [ID_W-1:0]     cmd_id,

  input  logic                din_valid,
  output logic                din_ready,
  input  logic [DATA_W-1:0]   din_data,

  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [1:0]          m_axi_awburst,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [ID_W-1:0]     m_axi_awuser,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,

  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,

  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,

  output logic                done,
  output logic [1:0]          done_resp,
  output logic                id_err,
  output logic                busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [2:0] AWSIZE = 3'($clog2(STRB_W));

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [7:0]        beat_q, beat_d;
  logic              done_q, done_d;
  logic [1:0]        done_resp_q, done_resp_d;
  logic              id_err_q, id_err_d;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic fifo_full, fifo_empty, push, pop, cmd_fire;

`ifdef AXI4_BURST_WRITER_TIMEOUT_EN
  logic [15:0] wdog_q, wdog_d;
`endif

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // din_ready uses the pre-pop full state, so a full FIFO never takes a
  // push even when a pop happens in the same cycle.
  assign din_ready  = !fifo_full;
  assign push       = din_valid && !fifo_full;
  assign pop        = m_axi_wvalid && m_axi_wready;
  assign cmd_ready  = (state_q == S_IDLE);
  assign cmd_fire   = cmd_valid && cmd_ready;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awid    = id_q;
  assign m_axi_awuser  = id_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = AWSIZE;
  assign m_axi_awvalid = (state_q == S_ADDR);

  // The head entry is read straight from the register array, so the next
  // beat is already presented the cycle after a pop with no bubble.
  assign m_axi_wdata  = mem_q[rd_ptr_q];
  assign m_axi_wstrb  = {STRB_W{1'b1}};
  assign m_axi_wvalid = (state_q == S_DATA) && !fifo_empty;
  assign m_axi_wlast  = m_axi_wvalid && (beat_q == 8'd0);

  assign m_axi_bready = (state_q == S_RESP);

  assign done      = done_q;
  assign done_resp = done_resp_q;
  assign id_err    = id_err_q;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    id_d        = id_q;
    beat_d      = beat_q;
    done_d      = 1'b0;
    done_resp_d = done_resp_q;
    id_err_d    = id_err_q;
`ifdef AXI4_BURST_WRITER_TIMEOUT_EN
    wdog_d      = wdog_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_fire) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          id_d    = cmd_id;
          beat_d  = cmd_len;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (m_axi_awready) state_d = S_DATA;
      end
      S_DATA: begin
        if (pop) begin
          if (beat_q == 8'd0) begin
            state_d = S_RESP;
`ifdef AXI4_BURST_WRITER_TIMEOUT_EN
            wdog_d  = 16'd0;
`endif
          end else begin
            beat_d = beat_q - 8'd1;
          end
        end
      end
      S_RESP: begin
        if (m_axi_bvalid) begin
          done_d      = 1'b1;
          done_resp_d = m_axi_bresp;
          if (m_axi_bid != id_q) id_err_d = 1'b1;
          state_d     = S_IDLE;
        end
`ifdef AXI4_BURST_WRITER_TIMEOUT_EN
        // Reaching 65535 aborts with SLVERR; done lands 65535 cycles
        // after RESP was entered.
        else if (wdog_q == 16'hFFFE) begin
          wdog_d      = 16'hFFFF;
          done_d      = 1'b1;
          done_resp_d = 2'b10;
          state_d     = S_IDLE;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      id_q        <= '0;
      beat_q      <= '0;
      done_q      <= 1'b0;
      done_resp_q <= 2'b00;
      id_err_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      id_q        <= id_d;
      beat_q      <= beat_d;
      done_q      <= done_d;
      done_resp_q <= done_resp_d;
      id_err_q    <= id_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_aresetn && push) mem_q[wr_ptr_q] <= din_data;
  end

`ifdef AXI4_BURST_WRITER_TIMEOUT_EN
  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) wdog_q <= 16'd0;
    else                wdog_q <= wdog_d;
  end
`endif

endmodule
